// File: rtl/wb_cmd_initiator_pkg.sv
// Shared types and constants for the Wishbone command initiator.
package wb_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Counter width able to hold the value `cycles` itself.
  function automatic int unsigned tmo_cnt_w(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/wb_cmd_initiator_if.sv
// Command, response and Wishbone master signals of the initiator.
interface wb_cmd_initiator_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_we_i;
  logic [AW-1:0]     cmd_adr_i;
  logic [DW-1:0]     cmd_dat_i;
  logic [DW/8-1:0]   cmd_sel_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DW-1:0]     rsp_dat_o;
  logic              rsp_err_o;
  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [DW/8-1:0]   wbm_sel_o;
  logic [AW-1:0]     wbm_adr_o;
  logic [DW-1:0]     wbm_dat_o;
  logic              wbm_ack_i;
  logic [DW-1:0]     wbm_dat_i;

  // Initiator side.
  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
           wbm_ack_i, wbm_dat_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  // Command source, response sink and Wishbone slave side.
  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
           wbm_ack_i, wbm_dat_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_cmd_initiator_timeout_ctr.sv
// Bus-cycle timeout counter: flags the cycle whose edge would bring the count to LIMIT.
module wb_timeout_ctr
  import wb_cmd_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);
  localparam int unsigned CW = tmo_cnt_w(LIMIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + CW'(1);
  end

  assign o_expired_c = i_en && (r_cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic master running one bus cycle per valid/ready command.
// Optional bus timeout abort enabled by defining WBM_TIMEOUT_EN.
module wb_cmd_initiator
  import wb_cmd_pkg::*;
#(
  parameter int unsigned   AW             = 32,
  parameter int unsigned   DW             = 32,
  parameter int unsigned   TIMEOUT_CYCLES = 255,
  parameter logic [DW-1:0] ERR_DATA       = DW'(ERR_DATA_DEFAULT)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  wb_cmd_initiator_if.master   bus,
  output logic                 busy_o
);
  localparam int unsigned SW = DW / 8;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e          r_state;
  logic            r_cyc;
  logic            r_we;
  logic [SW-1:0]   r_sel;
  logic [AW-1:0]   r_adr;
  logic [DW-1:0]   r_wdat;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_dat;
  logic            r_rsp_err;
  logic            r_busy;
  logic            w_expired;

`ifdef WBM_TIMEOUT_EN
  logic w_accept;
  logic w_bus_wait;

  assign w_accept   = bus.cmd_valid_i && (r_state == IDLE);
  assign w_bus_wait = (r_state == BUS) && !bus.wbm_ack_i;

  wb_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_ctr (
    .i_clk       (wb_clk_i),
    .i_rst_n     (wb_rst_ni),
    .i_clr       (w_accept),
    .i_en        (w_bus_wait),
    .o_expired_c (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // Command/bus/response sequencing; ack in BUS wins over a same-edge expiry.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state     <= IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_wdat      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            r_we    <= bus.cmd_we_i;
            r_adr   <= bus.cmd_adr_i;
            r_wdat  <= bus.cmd_dat_i;
            r_sel   <= bus.cmd_sel_i;
            r_cyc   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= BUS;
          end
        end
        BUS: begin
          if (bus.wbm_ack_i) begin
            r_rsp_dat   <= r_we ? '0 : bus.wbm_dat_i;
            r_rsp_err   <= 1'b0;
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (w_expired) begin
            r_rsp_dat   <= ERR_DATA;
            r_rsp_err   <= 1'b1;
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_cyc       <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o = (r_state == IDLE);
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_dat_o   = r_rsp_dat;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.wbm_cyc_o   = r_cyc;
  assign bus.wbm_stb_o   = r_cyc;
  assign bus.wbm_we_o    = r_we;
  assign bus.wbm_sel_o   = r_sel;
  assign bus.wbm_adr_o   = r_adr;
  assign bus.wbm_dat_o   = r_wdat;
  assign busy_o          = r_busy;
endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator with a small memory-backed Wishbone slave.
module tb_wb_cmd_initiator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  wb_cmd_initiator_if #(.AW(32), .DW(32)) bus ();

  wb_cmd_initiator #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus),
    .busy_o    (busy)
  );

  // Slave: acks after s_waits wait states (s_auto) or follows s_force.
  logic [31:0] mem [16];
  int unsigned s_wcnt = 0;
  int unsigned s_waits = 0;
  bit          s_auto = 1'b1;
  bit          s_force = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[2] <= 32'h1234_5678;
      s_wcnt <= 0;
    end else begin
      if (bus.wbm_cyc_o && !bus.wbm_ack_i) s_wcnt <= s_wcnt + 1;
      else                                 s_wcnt <= 0;
      if (bus.wbm_cyc_o && bus.wbm_ack_i && bus.wbm_we_o)
        for (int b = 0; b < 4; b++)
          if (bus.wbm_sel_o[b]) mem[bus.wbm_adr_o[5:2]][8*b +: 8] <= bus.wbm_dat_o[8*b +: 8];
    end
  end

  assign bus.wbm_ack_i = s_auto ? (bus.wbm_cyc_o && (s_wcnt == s_waits)) : s_force;
  assign bus.wbm_dat_i = mem[bus.wbm_adr_o[5:2]];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  int unsigned r_cyc_cnt;
  bit          r_stable;

  // Issue one command, then count and inspect the bus cycle until cyc drops.
  task automatic send_cmd(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    while (!bus.cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_bound", 32'(n < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = ~we;
    bus.cmd_adr_i   = 32'hFFFF_FFFF;
    bus.cmd_dat_i   = 32'h5555_AAAA;
    bus.cmd_sel_i   = 4'hA;
    r_cyc_cnt = 0;
    r_stable  = 1'b1;
    while (bus.wbm_cyc_o && r_cyc_cnt < 300) begin
      if (bus.wbm_stb_o !== 1'b1 || bus.wbm_we_o !== we || bus.wbm_adr_o !== adr ||
          bus.wbm_dat_o !== dat || bus.wbm_sel_o !== sel || bus.cmd_ready_o !== 1'b0 ||
          busy !== 1'b1)
        r_stable = 1'b0;
      r_cyc_cnt++;
      @(negedge clk);
    end
    chk("bus_bound", 32'(r_cyc_cnt < 300), 32'd1);
    chk("wbm_stable", 32'(r_stable), 32'd1);
    chk("rsp_valid_after_bus", 32'(bus.rsp_valid_o), 32'd1);
  endtask

  task automatic consume();
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    chk("rsp_dropped", 32'(bus.rsp_valid_o), 32'd0);
    chk("ready_in_idle", 32'(bus.cmd_ready_o), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int unsigned waits;
    int unsigned hold;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, 0, 0, 32'h0};
    vecs[1]  = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, 3, 5, 32'h1234_5678};
    vecs[2]  = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 1, 0, 32'hA5A5_5A5A};
    vecs[3]  = '{1'b1, 32'h3000_0004, 32'h1122_3344, 4'h3, 2, 0, 32'h0};
    vecs[4]  = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 0, 1, 32'hA5A5_3344};
    vecs[5]  = '{1'b1, 32'h3000_000C, 32'hFFFF_FFFF, 4'h0, 0, 0, 32'h0};
    vecs[6]  = '{1'b0, 32'h3000_000C, 32'h0,         4'h0, 0, 0, 32'h0};
    vecs[7]  = '{1'b1, 32'h3000_000C, 32'hCAFE_F00D, 4'hC, 1, 0, 32'h0};
    vecs[8]  = '{1'b0, 32'h3000_000C, 32'h0,         4'hF, 2, 2, 32'hCAFE_0000};
    vecs[9]  = '{1'b1, 32'h3000_0010, 32'hDEAD_0001, 4'hF, 0, 0, 32'h0};
    vecs[10] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 4, 0, 32'hDEAD_0001};
    vecs[11] = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, 0, 0, 32'h1234_5678};

    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.rsp_ready_i = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_rsp_dat", bus.rsp_dat_o, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);

    // Table: directed read/write sequence against the memory slave
    for (int i = 0; i < 12; i++) begin
      bit hold_ok;
      logic [31:0] snap;
      s_auto  = 1'b1;
      s_waits = vecs[i].waits;
      send_cmd(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel);
      chk($sformatf("v%0d_cyc_cycles", i), r_cyc_cnt, vecs[i].waits + 1);
      chk($sformatf("v%0d_rsp_dat", i), bus.rsp_dat_o, vecs[i].exp_dat);
      chk($sformatf("v%0d_rsp_err", i), 32'(bus.rsp_err_o), 32'd0);
      hold_ok = 1'b1;
      snap = bus.rsp_dat_o;
      for (int h = 0; h < int'(vecs[i].hold); h++) begin
        @(negedge clk);
        if (bus.rsp_valid_o !== 1'b1 || bus.rsp_dat_o !== snap || bus.cmd_ready_o !== 1'b0 ||
            bus.wbm_cyc_o !== 1'b0 || busy !== 1'b1)
          hold_ok = 1'b0;
      end
      chk($sformatf("v%0d_resp_hold", i), 32'(hold_ok), 32'd1);
      consume();
    end

    // Reset during a BUS wait state
    s_auto  = 1'b1;
    s_waits = 100;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b1;
    bus.cmd_adr_i   = 32'h3000_0010;
    bus.cmd_dat_i   = 32'h7777_7777;
    bus.cmd_sel_i   = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_cyc", 32'(bus.wbm_cyc_o), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    chk("mid_rst_stb", 32'(bus.wbm_stb_o), 32'd0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    s_waits = 0;
    send_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    chk("post_rst_cycles", r_cyc_cnt, 32'd1);
    chk("post_rst_rd", bus.rsp_dat_o, 32'h0);
    consume();

    // Spurious ack in IDLE
    s_auto  = 1'b0;
    s_force = 1'b1;
    repeat (2) @(negedge clk);
    s_force = 1'b0;
    chk("idle_ack_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("idle_ack_busy", 32'(busy), 32'd0);
    chk("idle_ack_cyc", 32'(bus.wbm_cyc_o), 32'd0);

    // Spurious ack in RESP
    s_auto  = 1'b1;
    s_waits = 0;
    send_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    s_auto  = 1'b0;
    s_force = 1'b1;
    @(negedge clk);
    s_force = 1'b0;
    @(negedge clk);
    chk("resp_ack_valid", 32'(bus.rsp_valid_o), 32'd1);
    chk("resp_ack_dat", bus.rsp_dat_o, 32'h1234_5678);
    chk("resp_ack_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    chk("resp_ack_ready", 32'(bus.cmd_ready_o), 32'd0);
    consume();

`ifdef WBM_TIMEOUT_EN
    // Slave never acks: abort after 8 BUS cycles, late ack ignored
    s_auto  = 1'b0;
    s_force = 1'b0;
    send_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    chk("to_cycles", r_cyc_cnt, 32'd8);
    chk("to_err", 32'(bus.rsp_err_o), 32'd1);
    chk("to_dat", bus.rsp_dat_o, 32'hDEAD_BEEF);
    @(negedge clk);
    s_force = 1'b1;
    @(negedge clk);
    s_force = 1'b0;
    chk("late_ack_valid", 32'(bus.rsp_valid_o), 32'd1);
    chk("late_ack_err", 32'(bus.rsp_err_o), 32'd1);
    chk("late_ack_dat", bus.rsp_dat_o, 32'hDEAD_BEEF);
    consume();
    // Ack on the expiry edge wins
    s_auto  = 1'b1;
    s_waits = 7;
    send_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    chk("exp_ack_cycles", r_cyc_cnt, 32'd8);
    chk("exp_ack_err", 32'(bus.rsp_err_o), 32'd0);
    chk("exp_ack_dat", bus.rsp_dat_o, 32'h1234_5678);
    consume();
`else
    // Without the timeout, a long wait still completes normally
    s_auto  = 1'b1;
    s_waits = 20;
    send_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    chk("long_wait_cycles", r_cyc_cnt, 32'd21);
    chk("long_wait_err", 32'(bus.rsp_err_o), 32'd0);
    chk("long_wait_dat", bus.rsp_dat_o, 32'h1234_5678);
    consume();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
